// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - FPU issue scheduler shared types and latency lookup
package fpu_sched_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    SQRT = 3'd3,
    CVT  = 3'd4,
    MISC = 3'd5
  } op_class_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rd_fpu;
  } slot_t;

  // Unused encodings fall through to the MISC latency.
  function automatic int class_lat(input logic [2:0] cls, input int lat_add, input int lat_mul,
                                   input int lat_div, input int lat_cvt, input int lat_misc);
    case (cls)
      ADD:       class_lat = lat_add;
      MUL:       class_lat = lat_mul;
      DIV, SQRT: class_lat = lat_div;
      CVT:       class_lat = lat_cvt;
      default:   class_lat = lat_misc;
    endcase
  endfunction

endpackage

// File: rtl/fpu_wb_slotq.sv
// rtl/fpu_wb_slotq.sv - writeback slot shift queue with indexed insert and occupancy probe
module fpu_wb_slotq
  import fpu_sched_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ins_en,
  input  logic [IW-1:0] ins_idx,
  input  slot_t         ins_data,
  input  logic [PW-1:0] probe_idx,
  output logic          probe_valid,
  output slot_t         head
);

  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];

  // Insert lands after the shift so a new entry occupies exactly its target index.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      slot_d[i] = slot_q[i+1];
    end
    slot_d[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_en && (ins_idx == IW'(i))) begin
        slot_d[i] = ins_data;
      end
    end
  end

  always_comb begin
    probe_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (probe_idx == PW'(i)) begin
        probe_valid = slot_q[i].valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  assign head = slot_q[0];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - FPU issue scheduler: hazard stall, scoreboards, divider occupancy, writeback
module fpu_issue_ctrl
  import fpu_sched_pkg::*;
#(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_CVT  = 2,
  parameter int LAT_MISC = 1,
  parameter int DEPTH    = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       issue_valid,
  input  logic [2:0] issue_class,
  input  logic [4:0] issue_rd,
  input  logic       issue_rd_fpu,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  input  logic       issue_rs1_fpu,
  input  logic       issue_rs2_fpu,
  input  logic       issue_rs2_used,
  input  logic       flush,
  output logic       stall,
  output logic       issue_fire,
  output logic       div_start,
  output logic       div_busy,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       wb_rd_fpu
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);
  localparam int CW = (LAT_DIV > 1) ? $clog2(LAT_DIV) : 1;

  logic [31:0]   sb_f_q, sb_f_d;
  logic [31:0]   sb_x_q, sb_x_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;

  int    lat;
  logic  is_div;
  logic  op_live;
  logic  rs1_pend, rs2_pend, rd_pend;
  logic  raw, waw, divh, wbh;
  logic  probe_valid;
  slot_t head;
  slot_t ins_data;

  assign lat    = class_lat(issue_class, LAT_ADD, LAT_MUL, LAT_DIV, LAT_CVT, LAT_MISC);
  assign is_div = (issue_class == DIV) || (issue_class == SQRT);

  // x0 is hardwired, so it is never a hazard source even if a bit were set.
  assign rs1_pend = issue_rs1_fpu ? sb_f_q[issue_rs1] : ((issue_rs1 != 5'd0) && sb_x_q[issue_rs1]);
  assign rs2_pend = issue_rs2_fpu ? sb_f_q[issue_rs2] : ((issue_rs2 != 5'd0) && sb_x_q[issue_rs2]);
  assign rd_pend  = issue_rd_fpu  ? sb_f_q[issue_rd]  : ((issue_rd  != 5'd0) && sb_x_q[issue_rd]);

  assign raw  = rs1_pend | (issue_rs2_used & rs2_pend);
  assign waw  = rd_pend;
  assign divh = is_div & div_busy;
  assign wbh  = (lat < DEPTH) & probe_valid;

  // Reset gates the combinational handshake so every output is quiet while rstn is low.
  assign op_live    = issue_valid & rstn & ~flush;
  assign stall      = op_live & (raw | waw | divh | wbh);
  assign issue_fire = op_live & ~stall;
  assign div_start  = issue_fire & is_div;
  assign div_busy   = (div_cnt_q != '0);

  assign ins_data = '{valid: 1'b1, rd: issue_rd, rd_fpu: issue_rd_fpu};

  fpu_wb_slotq #(
    .DEPTH (DEPTH)
  ) u_slotq (
    .clk         (clk),
    .rstn        (rstn),
    .ins_en      (issue_fire),
    .ins_idx     (IW'(lat - 1)),
    .ins_data    (ins_data),
    .probe_idx   (PW'(lat)),
    .probe_valid (probe_valid),
    .head        (head)
  );

  assign wb_valid  = head.valid;
  assign wb_rd     = head.rd;
  assign wb_rd_fpu = head.rd_fpu;

  // Set is applied after clear so a same-edge retire and reissue of one register stays pending.
  always_comb begin
    sb_f_d = sb_f_q;
    sb_x_d = sb_x_q;
    if (head.valid) begin
      if (head.rd_fpu) sb_f_d[head.rd] = 1'b0;
      else             sb_x_d[head.rd] = 1'b0;
    end
    if (issue_fire) begin
      if (issue_rd_fpu)            sb_f_d[issue_rd] = 1'b1;
      else if (issue_rd != 5'd0)   sb_x_d[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_start)         div_cnt_d = CW'(LAT_DIV - 1);
    else if (div_busy)     div_cnt_d = div_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_f_q    <= '0;
      sb_x_q    <= '0;
      div_cnt_q <= '0;
    end else begin
      sb_f_q    <= sb_f_d;
      sb_x_q    <= sb_x_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - scoreboard bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
  import fpu_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       issue_valid;
  logic [2:0] issue_class;
  logic [4:0] issue_rd;
  logic       issue_rd_fpu;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic       issue_rs1_fpu;
  logic       issue_rs2_fpu;
  logic       issue_rs2_used;
  logic       flush;
  logic       stall;
  logic       issue_fire;
  logic       div_start;
  logic       div_busy;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_rd_fpu;

  fpu_issue_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .issue_valid    (issue_valid),
    .issue_class    (issue_class),
    .issue_rd       (issue_rd),
    .issue_rd_fpu   (issue_rd_fpu),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_rs1_fpu  (issue_rs1_fpu),
    .issue_rs2_fpu  (issue_rs2_fpu),
    .issue_rs2_used (issue_rs2_used),
    .flush          (flush),
    .stall          (stall),
    .issue_fire     (issue_fire),
    .div_start      (div_start),
    .div_busy       (div_busy),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_rd_fpu      (wb_rd_fpu)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] rd;
    logic       fpu;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every writeback must match the oldest expectation, in its cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_wb: no writeback of rd=%0d fpu=%0d, required at cycle %0d", e.rd, e.fpu, e.cyc);
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wb: actual wb_rd=%0d fpu=%0d at cycle %0d, required none", wb_rd, wb_rd_fpu, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wb_cycle", cyc, e.cyc);
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("wb_rd_fpu", {31'd0, wb_rd_fpu}, {31'd0, e.fpu});
        end
      end
    end
  end

  task automatic push_wb(input int lat, input logic [4:0] rd, input logic fpu);
    exp_t x;
    x.cyc = cyc + lat;
    x.rd  = rd;
    x.fpu = fpu;
    exp_q.push_back(x);
  endtask

  task automatic present(input logic [2:0] c, input logic [4:0] rd, input logic rdf,
                         input logic [4:0] r1, input logic r1f,
                         input logic [4:0] r2, input logic r2f, input logic r2u);
    issue_valid    = 1'b1;
    flush          = 1'b0;
    issue_class    = c;
    issue_rd       = rd;
    issue_rd_fpu   = rdf;
    issue_rs1      = r1;
    issue_rs1_fpu  = r1f;
    issue_rs2      = r2;
    issue_rs2_fpu  = r2f;
    issue_rs2_used = r2u;
  endtask

  task automatic step(input logic es, input logic ef, input logic eds, input logic eb, input string nm);
    @(negedge clk);
    chk({nm, "_stall"}, {31'd0, stall}, {31'd0, es});
    chk({nm, "_fire"}, {31'd0, issue_fire}, {31'd0, ef});
    chk({nm, "_div_start"}, {31'd0, div_start}, {31'd0, eds});
    chk({nm, "_div_busy"}, {31'd0, div_busy}, {31'd0, eb});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    flush       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
    chk({nm, "_fire"}, {31'd0, issue_fire}, 32'd0);
    chk({nm, "_div_start"}, {31'd0, div_start}, 32'd0);
    chk({nm, "_div_busy"}, {31'd0, div_busy}, 32'd0);
    chk({nm, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({nm, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk({nm, "_wb_rd_fpu"}, {31'd0, wb_rd_fpu}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    present(ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    issue_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rstn = 1'b1;
    idle(2);

    // Single fadd f3: writeback 3 cycles after fire, pending bit set for those 3 cycles.
    present(ADD, 5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(3, 5'd3, 1'b1);
    step(0, 1, 0, 0, "single");
    issue_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("single_sb_f3", {31'd0, dut.sb_f_q[3]}, (k < 4) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    idle(2);

    // RAW: fmul f4 <- f3 waits for the fadd writeback.
    present(ADD, 5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(3, 5'd3, 1'b1);
    step(0, 1, 0, 0, "raw_src");
    present(MUL, 5'd4, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) step(1, 0, 0, 0, "raw_wait");
    push_wb(2, 5'd4, 1'b1);
    step(0, 1, 0, 0, "raw_go");
    idle(4);

    // Writeback port collision: fmul behind a fadd one cycle earlier.
    present(ADD, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b1);
    push_wb(3, 5'd1, 1'b1);
    step(0, 1, 0, 0, "wbc_add");
    present(MUL, 5'd2, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b1);
    step(1, 0, 0, 0, "wbc_wait");
    push_wb(2, 5'd2, 1'b1);
    step(0, 1, 0, 0, "wbc_go");
    idle(4);

    // Divider occupancy: fsqrt waits out the full fdiv.
    present(DIV, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(10, 5'd5, 1'b1);
    step(0, 1, 1, 0, "div_first");
    present(SQRT, 5'd6, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) step(1, 0, 0, 1, "div_wait");
    push_wb(10, 5'd6, 1'b1);
    step(0, 1, 1, 0, "div_second");
    idle(12);

    // x0 destination and x0 source never create hazards.
    present(MISC, 5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(1, 5'd0, 1'b0);
    step(0, 1, 0, 0, "x0_dst");
    present(MISC, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    push_wb(1, 5'd8, 1'b1);
    step(0, 1, 0, 0, "x0_src");
    chk("x0_sb_x", dut.sb_x_q, 32'd0);

    // x-reg RAW: fcvt reading x5 waits one cycle for the fle writeback.
    present(MISC, 5'd5, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(1, 5'd5, 1'b0);
    step(0, 1, 0, 0, "xraw_src");
    present(CVT, 5'd9, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1, 0, 0, 0, "xraw_wait");
    push_wb(2, 5'd9, 1'b1);
    step(0, 1, 0, 0, "xraw_go");
    idle(3);

    // Unused class encoding behaves as MISC (latency 1).
    present(3'd7, 5'd14, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(1, 5'd14, 1'b1);
    step(0, 1, 0, 0, "illegal_cls");
    idle(2);

    // Flush: no fire, no stall, nothing inserted.
    present(ADD, 5'd10, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    flush = 1'b1;
    step(0, 0, 0, 0, "flush");
    chk("flush_sb_f10", {31'd0, dut.sb_f_q[10]}, 32'd0);
    present(ADD, 5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(3, 5'd3, 1'b1);
    step(0, 1, 0, 0, "flush_haz_src");
    present(MUL, 5'd4, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b1);
    flush = 1'b1;
    step(0, 0, 0, 0, "flush_haz");
    idle(5);
    chk("flush_sb_f_idle", dut.sb_f_q, 32'd0);

    // Async reset with three slots in flight and the divider busy.
    present(DIV, 5'd11, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    step(0, 1, 1, 0, "rst_div");
    present(MUL, 5'd13, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    push_wb(2, 5'd13, 1'b1);
    step(0, 1, 0, 1, "rst_mul");
    present(ADD, 5'd12, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1);
    step(0, 1, 0, 1, "rst_add");
    present(MISC, 5'd15, 1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0);
    step(0, 1, 0, 1, "rst_misc");
    present(SQRT, 5'd20, 1'b1, 5'd21, 1'b1, 5'd0, 1'b1, 1'b0);
    #1;
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    chk("pre_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("pre_rst_wb_rd", {27'd0, wb_rd}, 32'd15);
    rstn = 1'b0;
    #1;
    chk_quiet("async_rst");
    repeat (2) @(posedge clk);
    #1;
    issue_valid = 1'b0;
    rstn = 1'b1;
    idle(15);
    chk("post_rst_sb_f", dut.sb_f_q, 32'd0);
    chk("post_rst_div_busy", {31'd0, div_busy}, 32'd0);

    chk("exp_queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Issue scheduler between the decode stage and the multi-cycle FPU datapath.
- Accepts one decoded FPU op per cycle and stalls decode on these hazards:
  - RAW or WAW against in-flight FPU results;
  - a busy non-pipelined divide/sqrt unit;
  - a collision on the single FPU writeback port.
- Tracks in-flight results in a writeback slot queue and drives writeback valid/destination to the register files (f-regs or x-regs).

Parameters:
- LAT_ADD, 3, fadd/fsub latency (pipelined)
- LAT_MUL, 2, fmul latency (pipelined)
- LAT_DIV, 10, fdiv/fsqrt latency; unit is non-pipelined
- LAT_CVT, 2, fcvt latency (pipelined)
- LAT_MISC, 1, fsgnj/feq/flt/fle/fmv latency
- DEPTH, 10, slot-queue depth; must be >= every LAT_*, and every LAT_* must be >= 1

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an FPU op
- issue_class  in  3  op class from fpu_sched_pkg: ADD, MUL, DIV, SQRT, CVT, MISC
- issue_rd  in  5  destination register
- issue_rd_fpu  in  1  1 = rd is an f-reg, 0 = rd is an x-reg
- issue_rs1, issue_rs2  in  5 each  source registers
- issue_rs1_fpu, issue_rs2_fpu  in  1 each  source register-file select
- issue_rs2_used  in  1  rs2 is read by the op
- flush  in  1  kill the presented op (branch redirect)
- stall  out  1  decode must hold the presented op
- issue_fire  out  1  op accepted this cycle
- div_start  out  1  pulse: start the divide/sqrt unit
- div_busy  out  1  divide/sqrt unit occupied
- wb_valid  out  1  FPU result writes back this cycle
- wb_rd  out  5  writeback destination
- wb_rd_fpu  out  1  writeback register-file select

Behaviour:
- Reset (rstn low, asynchronous):
  - all slots invalid, both scoreboards cleared, divide counter = 0;
  - outputs: stall=0, issue_fire=0, div_start=0, div_busy=0, wb_valid=0, wb_rd=0, wb_rd_fpu=0.
- Latency select: L = LAT_* chosen by issue_class; SQRT uses LAT_DIV.
- Scoreboards:
  - sb_f[31:0] and sb_x[31:0] hold one pending bit per register.
  - sb_x[0] is never set.
  - A source or destination equal to x0 never causes a hazard.
- Hazard conditions, all evaluated on registered state only (no bypass):
  - raw: the pending bit of rs1, or of rs2 when issue_rs2_used, is set.
  - waw: the pending bit of rd is set.
  - divh: class is DIV/SQRT and div_busy=1.
  - wbh: L < DEPTH and slot[L].valid=1 (that entry would shift into L-1 and collide).
- stall = issue_valid & ~flush & (raw | waw | divh | wbh).
- issue_fire = issue_valid & ~flush & ~stall. All of the above is combinational.
- Slot queue, updated every edge:
  - slot[i] <= slot[i+1], and slot[DEPTH-1] is cleared;
  - on fire, slot[L-1] <= {1, rd, rd_fpu}.
  - wb_valid, wb_rd and wb_rd_fpu are driven directly from slot[0].
  - An op fired in cycle t has wb_valid in cycle t+L.
- Scoreboard update at each edge:
  - slot[0].valid clears its pending bit;
  - fire sets the rd pending bit;
  - if the same bit is cleared and set in one edge, the set wins.
  - A dependent op can therefore fire in the cycle after wb_valid.
- Divide counter:
  - on a DIV/SQRT fire, load LAT_DIV-1; otherwise decrement while nonzero;
  - div_busy = (counter != 0); div_start = issue_fire & class is DIV/SQRT.
  - Back-to-back divides issue LAT_DIV cycles apart.
- flush: suppresses fire for the presented op only. Already-fired ops complete and write back (in-order commit point precedes the FPU).
- Reset mid-operation: all in-flight entries are discarded, and no wb_valid is issued after reset.
- Illegal class encodings: treated as MISC.

Decomposition:
- fpu_sched_pkg holds:
  - the op_class_e enum (ADD=0, MUL=1, DIV=2, SQRT=3, CVT=4, MISC=5);
  - the slot_t struct {valid, rd[4:0], rd_fpu};
  - a latency function mapping class to LAT_*.
- One sub-module, fpu_wb_slotq: the DEPTH-entry shift queue with insert-at-index and a collision-probe output.
- Scoreboards, hazard logic and the divide counter stay in fpu_issue_ctrl.

Test Plan:
- Single op:
  - Stimulus: fire fadd f3 (L=3) at cycle 5.
  - Required: wb_valid=1, wb_rd=3, wb_rd_fpu=1 in cycle 8 only.
  - Required: sb_f[3] is set in cycles 6-8 and cleared from cycle 9.
- RAW:
  - Stimulus: fadd f3 at t=0, then fmul f4,f3,f1 presented at t=1.
  - Required: stall=1 for t=1..3 and fire at t=4; that op writes back at t=6.
- Writeback collision:
  - Stimulus: fadd f1 (L=3) fires at t=0; at t=1 an fmul f2 (L=2, independent) is presented.
  - Required: the fmul stalls at t=1 (slot[2] valid) and fires at t=2.
  - Required: wb at t=3 (f1) and t=4 (f2).
- Divider occupancy:
  - Stimulus: fdiv f5 at t=0; fsqrt f6 presented at t=1.
  - Required: div_busy=1 for t=1..9, stall until t=10, fire and div_start at t=10, wb f6 at t=20.
- x0 and flush:
  - Stimulus: feq with rd=x0 fires, then an op reading x0 is presented next cycle.
  - Required: no stall; sb_x remains 0.
  - Stimulus: issue_valid=1 with flush=1.
  - Required: issue_fire=0, stall=0, no slot entry is inserted.
- Async reset:
  - Stimulus: assert rstn low mid-flight, with 3 valid slots and div_busy=1.
  - Required: all outputs drop to 0 immediately, with no clock edge.
  - Required: no wb_valid appears after rstn is released.
